i2s_tx: RTL and testbench

- Serialises signed 24-bit stereo audio samples into an I2S bit stream (SCLK, LRCK, SDATA) for the line-out DAC (Pmod I2S2 class codec).
- Sits at the output end of the synth chain, downstream of the waveform generator / mixer.
- Accepts one stereo pair per frame through a valid/ready handshake with a one-entry holding buffer.
- Repeats the last frame and flags underrun when no new sample is pending.

---
 rtl/synth_pkg.sv | 10 +
 rtl/i2s_clk_div.sv | 34 +++
 rtl/i2s_tx.sv | 81 ++++++++
 tb/tb_i2s_tx.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared constants and types for the synth audio output chain.
package synth_pkg;

  localparam int SAMPLE_W_DEFAULT = 24;
  localparam int BITS_PER_SLOT    = 32;
  localparam int BITS_PER_FRAME   = 64;

  typedef logic signed [SAMPLE_W_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/i2s_clk_div.sv
// Bit-clock divider: free-running SCLK plus single-cycle rise/fall strobes.
module i2s_clk_div #(
  parameter int SCLK_HALF = 4
) (
  input  logic clk,
  input  logic rst,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == CW'(SCLK_HALF - 1));
  // Strobes are true in the cycle whose edge flips sclk.
  assign rise = wrap & ~sclk;
  assign fall = wrap &  sclk;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      sclk    <= ~sclk;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-entry sample buffer, per-frame shadow load, MSB-first serialiser.
module i2s_tx
  import synth_pkg::*;
#(
  parameter int SAMPLE_W  = SAMPLE_W_DEFAULT,
  parameter int SCLK_HALF = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] sample_l,
  input  logic signed [SAMPLE_W-1:0] sample_r,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic                       underrun,
  output logic                       i2s_sclk,
  output logic                       i2s_lrck,
  output logic                       i2s_sdata
);

  logic                sclk_rise, sclk_fall;
  logic [5:0]          bit_cnt, nxt_bit;
  logic                frame_start;
  logic                buf_full;
  logic [SAMPLE_W-1:0] buf_l, buf_r, shadow_l, shadow_r;
  logic [BITS_PER_SLOT-1:0] slot_word;
  logic                nxt_sdata;

  i2s_clk_div #(.SCLK_HALF(SCLK_HALF)) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .sclk (i2s_sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  assign nxt_bit      = bit_cnt + 6'd1;
  assign frame_start  = sclk_fall && (bit_cnt == 6'd63);
  assign sample_ready = ~buf_full;

  // Slot word: position 0 is the I2S one-bit delay, then MSB..LSB, then zero pad.
  always_comb begin
    slot_word = '0;
    slot_word[BITS_PER_SLOT-2 -: SAMPLE_W] = nxt_bit[5] ? shadow_r : shadow_l;
    nxt_sdata = slot_word[5'd31 - nxt_bit[4:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= 6'd63;
      i2s_lrck  <= 1'b1;
      i2s_sdata <= 1'b0;
      shadow_l  <= '0;
      shadow_r  <= '0;
      buf_l     <= '0;
      buf_r     <= '0;
      buf_full  <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= frame_start & ~buf_full;
      if (sclk_fall) begin
        bit_cnt   <= nxt_bit;
        i2s_lrck  <= nxt_bit[5];
        i2s_sdata <= nxt_sdata;
      end
      // Consume takes priority; ready is low then, so no accept can collide.
      if (frame_start && buf_full) begin
        shadow_l <= buf_l;
        shadow_r <= buf_r;
        buf_full <= 1'b0;
      end else if (sample_valid && !buf_full) begin
        buf_l    <= sample_l;
        buf_r    <= sample_r;
        buf_full <= 1'b1;
      end
    end
  end

  a_rise_from_low: assert property (@(posedge clk) disable iff (rst) sclk_rise |-> !i2s_sclk);
  a_fall_from_high: assert property (@(posedge clk) disable iff (rst) sclk_fall |-> i2s_sclk);

endmodule

// File: tb/tb_i2s_tx.sv
// Randomised bench for i2s_tx: frame-level reference model feeding a scoreboard checked by a serial-stream decoder.
module tb_i2s_tx;
  localparam int SW       = 24;
  localparam int SH       = 2;
  localparam int FR       = 128 * SH;
  localparam int FIRST_FS = 2 * SH - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [SW-1:0] sample_l = '0;
  logic signed [SW-1:0] sample_r = '0;
  logic                 sample_valid = 1'b0;
  logic                 sample_ready, underrun, i2s_sclk, i2s_lrck, i2s_sdata;

  always #5 clk = ~clk;

  i2s_tx #(.SAMPLE_W(SW), .SCLK_HALF(SH)) dut (
    .clk(clk), .rst(rst),
    .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .underrun(underrun),
    .i2s_sclk(i2s_sclk), .i2s_lrck(i2s_lrck), .i2s_sdata(i2s_sdata)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame starts fall every 64 bit clocks, the first one 2*SH-1 edges after reset release.
  function automatic bit is_fs(input int e);
    return (e >= FIRST_FS) && (((e - FIRST_FS) % FR) == 0);
  endfunction

  function automatic int next_fs(input int e);
    if (e <= FIRST_FS) return FIRST_FS;
    return FIRST_FS + ((e - FIRST_FS + FR - 1) / FR) * FR;
  endfunction

  typedef struct packed { logic [SW-1:0] l; logic [SW-1:0] r; } frame_t;
  frame_t exp_q[$];

  int          cyc = 0;
  logic        m_full;
  logic [SW-1:0] m_bl, m_br, m_sl, m_sr;
  logic        exp_ready, exp_under;
  bit          chk_en = 0;
  bit          mon_flush = 0;
  int          frames_seen = 0;

  // Reference model: one pending pair, loaded at each frame start or else the last pair repeats.
  initial forever begin
    bit fs, acc;
    @(posedge clk);
    if (rst) begin
      cyc = 0; m_full = 0; m_bl = '0; m_br = '0; m_sl = '0; m_sr = '0;
      exp_ready = 1; exp_under = 0;
      exp_q.delete();
      mon_flush = 1; chk_en = 1;
    end else begin
      fs  = is_fs(cyc);
      acc = sample_valid && !m_full;
      exp_under = fs && !m_full;
      if (fs && m_full) begin
        m_sl = m_bl; m_sr = m_br; m_full = 0;
      end else if (acc) begin
        m_bl = sample_l; m_br = sample_r; m_full = 1;
      end
      if (fs) exp_q.push_back({m_sl, m_sr});
      exp_ready = !m_full;
      cyc++;
    end
  end

  // Handshake and underrun checked every cycle away from the active edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("ready", sample_ready, exp_ready);
      chk("underrun", underrun, exp_under);
    end
  end

  // Serial decoder: sample LRCK/SDATA on SCLK rise, frame begins where LRCK goes 1->0.
  initial begin
    logic [63:0] bits, lrs;
    logic [31:0] lw, rw;
    logic        prev_s, prev_l;
    int          idx;
    frame_t      e;
    bits = '0; lrs = '0; prev_s = 0; prev_l = 1; idx = 64;
    forever begin
      @(negedge clk);
      if (mon_flush) begin
        idx = 64; prev_l = 1; prev_s = 0; mon_flush = 0;
      end else if (chk_en) begin
        if (i2s_sclk && !prev_s) begin
          if (prev_l && !i2s_lrck) idx = 0;
          if (idx < 64) begin
            bits[idx] = i2s_sdata;
            lrs[idx]  = i2s_lrck;
            idx++;
            if (idx == 64) begin
              for (int i = 0; i < 32; i++) begin
                lw[31-i] = bits[i];
                rw[31-i] = bits[32+i];
              end
              frames_seen++;
              if (exp_q.size() == 0) begin
                chk("frame_queue_empty", 64'd0, 64'd1);
              end else begin
                e = exp_q.pop_front();
                chk("left_slot", lw, {1'b0, e.l, 7'b0});
                chk("right_slot", rw, {1'b0, e.r, 7'b0});
                chk("lrck_slots", lrs, 64'hFFFF_FFFF_0000_0000);
              end
            end
          end
          prev_l = i2s_lrck;
        end
        prev_s = i2s_sclk;
      end
    end
  end

  task automatic wait_cyc(input int target);
    int g;
    g = 0;
    while (cyc < target && g < 4 * FR) begin
      @(negedge clk);
      g++;
    end
    chk("wait_cyc", cyc, target);
  endtask

  task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r);
    int g;
    sample_l = l; sample_r = r; sample_valid = 1;
    g = 0;
    while (!sample_ready && g < 4 * FR) begin
      @(negedge clk);
      g++;
    end
    chk("send_ready", sample_ready, 1);
    @(negedge clk);
    sample_valid = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sclk"}, i2s_sclk, 0);
    chk({tag, "_lrck"}, i2s_lrck, 1);
    chk({tag, "_sdata"}, i2s_sdata, 0);
    chk({tag, "_ready"}, sample_ready, 1);
    chk({tag, "_underrun"}, underrun, 0);
  endtask

  initial begin
    logic [3:0]    scv, lrv;
    logic [SW-1:0] base;
    logic          was_ready;
    int            f, k;

    // Reset with no stimulus: waveform timing and silent underrunning frames.
    rst = 1;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      scv[i] = i2s_sclk;
      lrv[i] = i2s_lrck;
    end
    chk("sclk_wave", scv, 4'b0110);
    chk("lrck_first_fall", lrv, 4'b0111);
    repeat (2 * FR) @(negedge clk);

    // Boundary values pushed before the first frame start.
    rst = 1;
    @(negedge clk);
    rst = 0;
    sample_l = 24'h800001; sample_r = 24'h7FFFFF; sample_valid = 1;
    @(negedge clk);
    sample_valid = 0;
    repeat (2 * FR) @(negedge clk);

    // One pair, then starve for three frames.
    send(SW'($urandom), SW'($urandom));
    repeat (4 * FR) @(negedge clk);

    // Back-to-back stream of consecutive values.
    base = SW'($urandom);
    k = 0;
    sample_l = base; sample_r = ~base; sample_valid = 1;
    was_ready = sample_ready;
    for (int i = 0; i < 6 * FR; i++) begin
      @(negedge clk);
      if (was_ready) begin
        k++;
        sample_l = base + SW'(k);
        sample_r = ~(base + SW'(k));
      end
      was_ready = sample_ready;
    end
    sample_valid = 0;
    repeat (2 * FR) @(negedge clk);

    // Valid offered exactly on the frame-start clock with an empty buffer.
    f = next_fs(cyc + 1);
    wait_cyc(f);
    sample_l = SW'($urandom); sample_r = SW'($urandom); sample_valid = 1;
    @(negedge clk);
    sample_valid = 0;
    chk("fs_valid_underrun", underrun, 1);
    chk("fs_valid_taken", sample_ready, 0);
    repeat (2 * FR) @(negedge clk);

    // Reset in the right slot (bit 40) with a pair pending.
    f = next_fs(cyc + 1);
    wait_cyc(f + 10);
    send(SW'($urandom), SW'($urandom));
    wait_cyc(f + 2 * SH * 40 + 1);
    chk("pre_rst_right_slot", i2s_lrck, 1);
    chk("pre_rst_pending", sample_ready, 0);
    rst = 1;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst = 0;
    repeat (2 * FR + 20) @(negedge clk);

    chk("frames_seen_min", frames_seen >= 20, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
